// File: rtl/bus_sequencer_pkg.sv
// +----------------------------------------------------------------------+
// | bus_sequencer_pkg : shared ROM word types and width helpers           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package bus_sequencer_pkg;

   localparam int c_ROM_ADDR_WIDTH = 8;
   localparam int c_ROM_DATA_WIDTH = 13;
   localparam int c_N_REQ_MAX      = 8;

   // Width of an index/counter able to hold 0..v-1, never narrower than 1 bit.
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

   typedef logic [c_ROM_DATA_WIDTH-1:0]           word_ut;
   typedef logic [clog2_min1(c_N_REQ_MAX)-1:0]    req_id_t;

endpackage

`default_nettype wire

// File: rtl/bus_sequencer_rr_picker.sv
// +----------------------------------------------------------------------+
// | bus_sequencer_rr_picker : rotate-priority picker, search from ptr+1   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module bus_sequencer_rr_picker
   import bus_sequencer_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0] i_req,
   input  req_id_t          i_ptr,
   output logic [N_REQ-1:0] o_gnt,
   output req_id_t          o_idx,
   output logic             o_any
);

   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      // Offset k=N_REQ wraps back onto ptr itself, so the last winner is checked last.
      for (int k = 1; k <= N_REQ; k++) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (!o_any && i_req[i] &&
                (((int'(i_ptr) + k) >= N_REQ) ? (int'(i_ptr) + k - N_REQ)
                                               : (int'(i_ptr) + k)) == i) begin
               o_any    = 1'b1;
               o_gnt[i] = 1'b1;
               o_idx    = req_id_t'(i);
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/bus_sequencer_rom_arbiter.sv
// +----------------------------------------------------------------------+
// | bus_sequencer_rom_arbiter : shares one ROM port between N readers     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module bus_sequencer_rom_arbiter
   import bus_sequencer_pkg::*;
#(
   parameter int N_REQ          = 4,
   parameter int ROM_ADDR_WIDTH = c_ROM_ADDR_WIDTH,
   parameter int ROM_DATA_WIDTH = c_ROM_DATA_WIDTH,
   parameter int ROM_LATENCY    = 1,
   parameter int MAX_BURST      = 4
) (
   input  logic                          clk_i,
   input  logic                          nrst_i,
   input  logic                          en_i,
   input  logic [N_REQ-1:0]              req_i,
   input  logic [N_REQ*ROM_ADDR_WIDTH-1:0] addr_i,
   output logic [N_REQ-1:0]              gnt_o,
   output logic [N_REQ-1:0]              rvalid_o,
   output logic [ROM_DATA_WIDTH-1:0]     rdata_o,
   output logic                          rom_rden_o,
   output logic [ROM_ADDR_WIDTH-1:0]     rom_addr_o,
   input  logic [ROM_DATA_WIDTH-1:0]     rom_data_i
);

   localparam int                   c_BURST_W = clog2_min1(MAX_BURST);
   localparam logic [c_BURST_W-1:0] c_BURST_LIM = c_BURST_W'(MAX_BURST - 1);
   localparam int                   c_PIPE_D  = ROM_LATENCY + 1;

   req_id_t                     r_ptr;
   logic [N_REQ-1:0]            r_last_oh;
   logic [c_BURST_W-1:0]        r_burst;
   logic                        r_rden;
   logic [ROM_ADDR_WIDTH-1:0]   r_addr;
   logic [N_REQ-1:0]            r_pipe [c_PIPE_D];
   logic [N_REQ-1:0]            r_rvalid;
   logic [ROM_DATA_WIDTH-1:0]   r_rdata;

   logic [N_REQ-1:0]            w_pick_oh;
   req_id_t                     w_pick_idx;
   logic                        w_pick_any;
   logic                        w_stick;
   logic                        w_grant;
   logic [N_REQ-1:0]            w_gnt;
   logic [ROM_ADDR_WIDTH-1:0]   w_addr_sel;

   bus_sequencer_rr_picker #(
      .N_REQ (N_REQ)
   ) u_picker (
      .i_req (req_i),
      .i_ptr (r_ptr),
      .o_gnt (w_pick_oh),
      .o_idx (w_pick_idx),
      .o_any (w_pick_any)
   );

   // r_last_oh is zero after reset, so the first grant always goes through rotation.
   assign w_stick = (|(req_i & r_last_oh)) && (r_burst != c_BURST_LIM);
   assign w_grant = nrst_i && en_i && w_pick_any;
   assign w_gnt   = w_grant ? (w_stick ? r_last_oh : w_pick_oh) : '0;
   assign gnt_o   = w_gnt;

   always_comb begin
      w_addr_sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_gnt[i]) begin
            w_addr_sel = addr_i[i*ROM_ADDR_WIDTH +: ROM_ADDR_WIDTH];
         end
      end
   end

   // Owner pipe holds the one-hot id; a non-zero entry doubles as its valid bit.
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         r_ptr     <= req_id_t'(N_REQ - 1);
         r_last_oh <= '0;
         r_burst   <= '0;
         r_rden    <= 1'b0;
         r_addr    <= '0;
         for (int k = 0; k < c_PIPE_D; k++) begin
            r_pipe[k] <= '0;
         end
         r_rvalid  <= '0;
         r_rdata   <= '0;
      end else begin
         r_rden <= w_grant;
         if (w_grant) begin
            r_addr    <= w_addr_sel;
            r_last_oh <= w_gnt;
            if (w_stick) begin
               r_burst <= r_burst + c_BURST_W'(1);
            end else begin
               r_burst <= '0;
               r_ptr   <= w_pick_idx;
            end
         end
         r_pipe[0] <= w_gnt;
         for (int k = 1; k < c_PIPE_D; k++) begin
            r_pipe[k] <= r_pipe[k-1];
         end
         r_rvalid <= r_pipe[c_PIPE_D-1];
         if (|r_pipe[c_PIPE_D-1]) begin
            r_rdata <= rom_data_i;
         end
      end
   end

   assign rvalid_o   = r_rvalid;
   assign rdata_o    = r_rdata;
   assign rom_rden_o = r_rden;
   assign rom_addr_o = r_addr;

endmodule

`default_nettype wire
